// File: rtl/updown_meet_counter.sv
// Paired up/down counter: launches on start, steps both counts toward each other,
// and flags with a one-cycle pulse whether the run ended equal (meet) or crossed.
module updown_meet_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_en,
  output logic [WIDTH-1:0] count_up,
  output logic [WIDTH-1:0] count_down,
  output logic             busy,
  output logic             done,
  output logic             meet,
  output logic             crossed
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] up_nxt;
  logic [WIDTH-1:0] down_nxt;
  logic             meet_nxt;
  logic             crossed_nxt;

  // State and output registers; busy/done track the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count_up   <= '0;
      count_down <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      meet       <= 1'b0;
      crossed    <= 1'b0;
    end else begin
      state      <= state_nxt;
      count_up   <= up_nxt;
      count_down <= down_nxt;
      busy       <= (state_nxt == RUN);
      done       <= (state_nxt == DONE);
      meet       <= meet_nxt;
      crossed    <= crossed_nxt;
    end
  end

  // Termination is checked on the current counts before any step is taken.
  always_comb begin
    state_nxt   = state;
    up_nxt      = count_up;
    down_nxt    = count_down;
    meet_nxt    = 1'b0;
    crossed_nxt = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          up_nxt    = '0;
          down_nxt  = load_val;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count_up == count_down) begin
          meet_nxt  = 1'b1;
          state_nxt = DONE;
        end else if (count_up > count_down) begin
          crossed_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (step_en) begin
          up_nxt   = count_up + WIDTH'(1);
          down_nxt = count_down - WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
